// File: rtl/pulse_stretcher.sv
// Rising-edge triggered pulse stretcher: holds out/busy high for max(len,1) cycles, then pulses done.
// Optional PULSE_STRETCHER_QUEUE_EN (RETRIGGER=0 only) queues edges seen during a hold and replays them.
module pulse_stretcher #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RETRIGGER = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic [WIDTH-1:0] len,
  output logic             out,
  output logic             busy,
  output logic             done
);

`ifdef PULSE_STRETCHER_QUEUE_EN
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  localparam bit              QUEUE_ON = (RETRIGGER == 0);
  localparam int unsigned     PEND_W   = 4;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend_q, pend_d;
`else
  typedef enum logic {IDLE, HOLD} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_q;
  logic             trig;
  logic [WIDTH-1:0] len_eff;

  assign trig    = in & ~in_q;
  assign len_eff = (len == '0) ? WIDTH'(1) : len;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PULSE_STRETCHER_QUEUE_EN
    pend_d  = pend_q;
    if (QUEUE_ON && trig && (state_q != IDLE) && (pend_q != PEND_MAX)) begin
      pend_d = pend_q + PEND_W'(1);
    end
`endif
    case (state_q)
      IDLE: begin
        out_d  = 1'b0;
        busy_d = 1'b0;
        if (trig) begin
          state_d = HOLD;
          cnt_d   = len_eff;
          out_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      HOLD: begin
        out_d  = 1'b1;
        busy_d = 1'b1;
        cnt_d  = cnt_q - WIDTH'(1);
        if (trig && (RETRIGGER != 0)) begin
          cnt_d = len_eff;
        end else if (cnt_q <= WIDTH'(1)) begin
`ifdef PULSE_STRETCHER_QUEUE_EN
          // A trig on the last cycle counts as pending too, so it is never stranded in IDLE.
          if (QUEUE_ON && ((pend_q != '0) || trig)) begin
            state_d = GAP;
            out_d   = 1'b0;
          end else begin
            state_d = IDLE;
            out_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
`else
          state_d = IDLE;
          out_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef PULSE_STRETCHER_QUEUE_EN
      GAP: begin
        state_d = HOLD;
        cnt_d   = len_eff;
        out_d   = 1'b1;
        busy_d  = 1'b1;
        pend_d  = trig ? pend_q : (pend_q - PEND_W'(1));
      end
`endif
      default: begin
        state_d = IDLE;
        out_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      in_q    <= 1'b0;
`ifdef PULSE_STRETCHER_QUEUE_EN
      pend_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      in_q    <= in;
`ifdef PULSE_STRETCHER_QUEUE_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Table-driven bench: one retriggering and one non-retriggering instance share stimulus.
module tb_pulse_stretcher;

  localparam int unsigned WIDTH = 8;
`ifdef PULSE_STRETCHER_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  // {out, busy, done}
  localparam logic [2:0] I0 = 3'b000;
  localparam logic [2:0] H  = 3'b110;
  localparam logic [2:0] D  = 3'b001;
  localparam logic [2:0] G  = 3'b010;

  typedef struct {
    string            tag;
    logic             in_v;
    logic [WIDTH-1:0] len_v;
    logic             rst_v;
    logic [2:0]       ea;
    logic [2:0]       eb;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_s;
  logic [WIDTH-1:0] len_s;
  logic             oa, ba, da;
  logic             ob, bb, db;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pulse_stretcher #(.WIDTH(WIDTH), .RETRIGGER(1)) u_rt (
    .clk(clk), .reset(rst), .in(in_s), .len(len_s),
    .out(oa), .busy(ba), .done(da)
  );

  pulse_stretcher #(.WIDTH(WIDTH), .RETRIGGER(0)) u_nr (
    .clk(clk), .reset(rst), .in(in_s), .len(len_s),
    .out(ob), .busy(bb), .done(db)
  );

  function automatic logic [2:0] qb(input logic [2:0] dflt, input logic [2:0] qd);
    return QUEUE ? qd : dflt;
  endfunction

  task automatic row(input string tag, input logic i, input logic [WIDTH-1:0] l,
                     input logic r, input logic [2:0] ea, input logic [2:0] eb);
    vec_t v;
    v.tag = tag; v.in_v = i; v.len_v = l; v.rst_v = r; v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic check3(input string name, input int step, input logic [2:0] got,
                        input logic [2:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step %0d: got obd=%b want %b", name, step, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic build_table();
    logic [2:0] a[];
    logic [2:0] b[];
    logic       iv[];
    // reset state
    row("rst", 1'b0, 8'd4, 1'b1, I0, I0);
    row("rst", 1'b0, 8'd4, 1'b1, I0, I0);
    // len=4, input held high: single 4-cycle pulse
    for (int s = 0; s < 4; s++) row("held", 1'b1, 8'd4, 1'b0, H, H);
    row("held", 1'b1, 8'd4, 1'b0, D, D);
    for (int s = 0; s < 5; s++) row("held", 1'b1, 8'd4, 1'b0, I0, I0);
    row("held", 1'b0, 8'd4, 1'b0, I0, I0);
    // len=0 behaves as 1
    row("len0", 1'b1, 8'd0, 1'b0, H, H);
    row("len0", 1'b0, 8'd0, 1'b0, D, D);
    row("len0", 1'b0, 8'd0, 1'b0, I0, I0);
    // len=5, second edge 3 cycles after the first
    iv = '{1,0,0,1,0,0,0,0,0,0,0,0};
    a  = '{H,H,H,H,H,H,H,H,D,I0,I0,I0};
    b  = '{H,H,H,H,H,D,I0,I0,I0,I0,I0,I0};
    for (int s = 0; s < 12; s++)
      row("rt3", iv[s], 8'd5, 1'b0, a[s], qb(b[s], (s < 5) ? H : (s == 5) ? G : (s == 11) ? D : H));
    // len=5, second edge on the final high cycle
    iv = '{1,0,0,0,0,1,0,0,0,0,0,0};
    a  = '{H,H,H,H,H,H,H,H,H,H,D,I0};
    for (int s = 0; s < 12; s++)
      row("rtlast", iv[s], 8'd5, 1'b0, a[s],
          qb((s < 5) ? H : (s == 5) ? D : I0, (s < 5) ? H : (s == 5) ? G : (s == 11) ? D : H));
    // len=5, second edge 2 cycles in
    iv = '{1,0,1,0,0,0,0,0,0,0,0,0};
    a  = '{H,H,H,H,H,H,H,D,I0,I0,I0,I0};
    for (int s = 0; s < 12; s++)
      row("nr2", iv[s], 8'd5, 1'b0, a[s],
          qb((s < 5) ? H : (s == 5) ? D : I0, (s < 5) ? H : (s == 5) ? G : (s == 11) ? D : H));
    // len=3, extra edges in hold and in gap
    iv = '{1,0,1,0,1,0,0,0,0,0,0,0,0};
    a  = '{H,H,H,H,H,H,H,D,I0,I0,I0,I0,I0};
    b  = '{H,H,H,D,H,H,H,D,I0,I0,I0,I0,I0};
    for (int s = 0; s < 13; s++)
      row("queue", iv[s], 8'd3, 1'b0, a[s],
          qb(b[s], (s == 3 || s == 7) ? G : (s == 11) ? D : (s == 12) ? I0 : H));
    // trig in the done cycle is accepted
    iv = '{1,0,0,1,0,0,0};
    a  = '{H,H,D,H,H,D,I0};
    for (int s = 0; s < 7; s++) row("donetrig", iv[s], 8'd2, 1'b0, a[s], a[s]);
    // reset mid-hold, input held across release, len change mid-hold ignored
    row("rstmid", 1'b1, 8'd6, 1'b0, H, H);
    row("rstmid", 1'b1, 8'd6, 1'b0, H, H);
    row("rstmid", 1'b1, 8'd6, 1'b1, I0, I0);
    row("rstmid", 1'b1, 8'd6, 1'b1, I0, I0);
    row("rstmid", 1'b1, 8'd6, 1'b0, H, H);
    row("rstmid", 1'b1, 8'd6, 1'b0, H, H);
    for (int s = 0; s < 4; s++) row("rstmid", 1'b1, 8'd2, 1'b0, H, H);
    row("rstmid", 1'b1, 8'd2, 1'b0, D, D);
    row("rstmid", 1'b1, 8'd2, 1'b0, I0, I0);
    row("rstmid", 1'b0, 8'd2, 1'b0, I0, I0);
  endtask

  initial begin
    int ca, cb, da_at, db_at;
    rst   = 1'b1;
    in_s  = 1'b0;
    len_s = '0;
    build_table();

    foreach (vecs[k]) begin
      in_s  = vecs[k].in_v;
      len_s = vecs[k].len_v;
      rst   = vecs[k].rst_v;
      @(posedge clk);
      #1;
      check3({vecs[k].tag, "_rt"}, k, {oa, ba, da}, vecs[k].ea);
      check3({vecs[k].tag, "_nr"}, k, {ob, bb, db}, vecs[k].eb);
    end

    // Maximum length: 255 high cycles, done on the following one
    ca = 0; cb = 0; da_at = 0; db_at = 0;
    len_s = 8'd255;
    in_s  = 1'b1;
    for (int s = 1; s <= 300; s++) begin
      if (s == 2) in_s = 1'b0;
      @(posedge clk);
      #1;
      if (oa) ca++;
      if (ob) cb++;
      if (da && da_at == 0) da_at = s;
      if (db && db_at == 0) db_at = s;
    end
    check_int("max_high_rt", ca, 255);
    check_int("max_high_nr", cb, 255);
    check_int("max_done_rt", da_at, 256);
    check_int("max_done_nr", db_at, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
